// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data-memory responder. Accepts one
//                load/store request at a time, waits a fixed LATENCY, then
//                commits the store or performs the load. It holds the response
//                until the initiator consumes it.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH_WORDS  number of 32-bit words (power of two, 4..1024)
//    LATENCY      cycles from request acceptance to rsp_valid (1..4)
//  Ports
//    clk          clock, all state changes on the rising edge
//    rst          asynchronous active-high reset
//    req_valid    initiator presents a request
//    req_ready    responder can accept a request (IDLE only)
//    req_we       1 = store, 0 = load
//    req_addr     byte address (wraps modulo DEPTH_WORDS*4)
//    req_wdata    store data, sub-word stores use the low bits
//    req_dmtype   000 w, 001 h, 010 hu, 011 b, 100 bu, others illegal
//    rsp_valid    response available
//    rsp_ready    initiator consumes the response
//    rsp_rdata    extended load data; 0 for stores and errors
//    rsp_err      misaligned or illegal access, qualified by rsp_valid
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int       c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int       c_ADDR_W = c_IDX_W + 2;
    localparam int       c_CNT_W  = 3;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(LATENCY - 1);

    localparam logic [2:0] c_DM_W  = 3'b000;
    localparam logic [2:0] c_DM_H  = 3'b001;
    localparam logic [2:0] c_DM_HU = 3'b010;
    localparam logic [2:0] c_DM_B  = 3'b011;
    localparam logic [2:0] c_DM_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic [c_CNT_W-1:0]    cnt_q,       cnt_d;
    logic                  we_q,        we_d;
    logic [c_ADDR_W-1:0]   addr_q,      addr_d;
    logic [31:0]           wdata_q,     wdata_d;
    logic [2:0]            dmtype_q,    dmtype_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    // Storage array; intentionally has no reset.
    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_commit;
    logic [c_IDX_W-1:0]    w_idx;
    logic [1:0]            w_lane;
    logic                  w_err;
    logic [31:0]           w_rd_word;
    logic [7:0]            w_rd_byte;
    logic [15:0]           w_rd_half;
    logic [31:0]           w_load_data;
    logic [3:0]            w_be;
    logic [31:0]           w_wr_data;
    logic                  w_mem_we;
    logic                  w_unused_addr;

    // Upper address bits fold away: the memory wraps modulo DEPTH_WORDS*4.
    assign w_unused_addr = ^req_addr[31:c_ADDR_W];

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    // rst gates req_ready so it stays low while reset is asserted, yet it
    // rises in the very first cycle after rst is released.
    assign req_ready = (state_q == S_IDLE) & ~rst;
    assign w_accept  = req_valid & req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Commit/read edge: last BUSY cycle, when the latency counter is spent.
    assign w_commit  = (state_q == S_BUSY) && (cnt_q == '0);

    // ------------------------------------------------------------------
    // Access decode (from latched request fields only)
    // ------------------------------------------------------------------
    assign w_idx  = addr_q[c_ADDR_W-1:2];
    assign w_lane = addr_q[1:0];

    always_comb begin
        w_err = 1'b0;
        case (dmtype_q)
            c_DM_W:          w_err = (w_lane != 2'b00);
            c_DM_H, c_DM_HU: w_err = w_lane[0];
            c_DM_B, c_DM_BU: w_err = 1'b0;
            default:         w_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    assign w_rd_word = mem[w_idx];

    always_comb begin
        w_rd_byte = w_rd_word[7:0];
        case (w_lane)
            2'd0: w_rd_byte = w_rd_word[7:0];
            2'd1: w_rd_byte = w_rd_word[15:8];
            2'd2: w_rd_byte = w_rd_word[23:16];
            2'd3: w_rd_byte = w_rd_word[31:24];
            default: w_rd_byte = w_rd_word[7:0];
        endcase
    end

    assign w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (dmtype_q)
            c_DM_W:  w_load_data = w_rd_word;
            c_DM_H:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
            c_DM_HU: w_load_data = {16'h0, w_rd_half};
            c_DM_B:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
            c_DM_BU: w_load_data = {24'h0, w_rd_byte};
            default: w_load_data = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: replicate the narrow data across lanes and let the byte
    // enables pick which lanes land, so unselected bytes are untouched.
    // ------------------------------------------------------------------
    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = wdata_q;
        case (dmtype_q)
            c_DM_W: begin
                w_be      = 4'b1111;
                w_wr_data = wdata_q;
            end
            c_DM_H, c_DM_HU: begin
                w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{wdata_q[15:0]}};
            end
            c_DM_B, c_DM_BU: begin
                w_be      = 4'b0001 << w_lane;
                w_wr_data = {4{wdata_q[7:0]}};
            end
            default: begin
                w_be      = 4'b0000;
                w_wr_data = wdata_q;
            end
        endcase
    end

    assign w_mem_we = w_commit & we_q & ~w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dmtype_d    = dmtype_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d  = S_BUSY;
                    cnt_d    = c_LAT_M1;
                    we_d     = req_we;
                    addr_d   = req_addr[c_ADDR_W-1:0];
                    wdata_d  = req_wdata;
                    dmtype_d = req_dmtype;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    // Same edge as the memory write; the read sees the
                    // pre-write word, which only matters for stores whose
                    // rdata is forced to zero anyway.
                    state_d     = S_RESP;
                    rsp_err_d   = w_err;
                    rsp_rdata_d = (we_q || w_err) ? 32'h0 : w_load_data;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            dmtype_q    <= 3'b000;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dmtype_q    <= dmtype_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_DEPTH = 64;
    localparam int c_LAT   = 2;

    localparam logic [2:0] c_W  = 3'b000;
    localparam logic [2:0] c_H  = 3'b001;
    localparam logic [2:0] c_HU = 3'b010;
    localparam logic [2:0] c_B  = 3'b011;
    localparam logic [2:0] c_BU = 3'b100;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dmtype;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .LATENCY     (c_LAT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_dmtype (req_dmtype),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request, then scrambles the inputs after acceptance and
    // waits for rsp_valid, checking the acceptance-to-response latency.
    // Entered and left just after a rising edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] dmt, input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_dmtype = dmt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_dmtype = 3'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(c_LAT));
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] dmt, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
        send(we, addr, wdata, dmt, tag);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        take();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_dmtype = 3'b000;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Basic store / load
        xact(1'b1, 32'h10, 32'hDEADBEEF, c_W, 32'h0, 1'b0, "sw_10");
        check("after_hs_ready", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h10, 32'h0, c_W, 32'hDEADBEEF, 1'b0, "lw_10");

        // Byte store over the word; upper wdata bits must be ignored
        xact(1'b1, 32'h13, 32'hFFFFFF5A, c_B, 32'h0, 1'b0, "sb_13");
        xact(1'b0, 32'h10, 32'h0, c_W, 32'h5AADBEEF, 1'b0, "lw_10b");
        xact(1'b0, 32'h13, 32'h0, c_B, 32'h0000005A, 1'b0, "lb_13");
        xact(1'b0, 32'h12, 32'h0, c_H, 32'h00005AAD, 1'b0, "lh_12");

        // Sign / zero extension
        xact(1'b1, 32'h20, 32'h80FF8001, c_W, 32'h0, 1'b0, "sw_20");
        xact(1'b0, 32'h20, 32'h0, c_B,  32'h00000001, 1'b0, "lb_20");
        xact(1'b0, 32'h21, 32'h0, c_B,  32'hFFFFFF80, 1'b0, "lb_21");
        xact(1'b0, 32'h21, 32'h0, c_BU, 32'h00000080, 1'b0, "lbu_21");
        xact(1'b0, 32'h22, 32'h0, c_H,  32'hFFFF80FF, 1'b0, "lh_22");
        xact(1'b0, 32'h22, 32'h0, c_HU, 32'h000080FF, 1'b0, "lhu_22");
        xact(1'b0, 32'h20, 32'h0, c_H,  32'hFFFF8001, 1'b0, "lh_20");
        xact(1'b0, 32'h20, 32'h0, c_HU, 32'h00008001, 1'b0, "lhu_20");

        // Halfword store into the upper lane
        xact(1'b1, 32'h22, 32'h1234ABCD, c_HU, 32'h0, 1'b0, "shu_22");
        xact(1'b0, 32'h20, 32'h0, c_W,  32'hABCD8001, 1'b0, "lw_20");
        xact(1'b0, 32'h23, 32'h0, c_BU, 32'h000000AB, 1'b0, "lbu_23");

        // Errors: response still arrives on time, memory untouched
        xact(1'b1, 32'h12, 32'h11111111, c_W, 32'h0, 1'b1, "sw_12_err");
        xact(1'b0, 32'h10, 32'h0, c_W, 32'h5AADBEEF, 1'b0, "lw_10_keep");
        xact(1'b0, 32'h11, 32'h0, c_H, 32'h0, 1'b1, "lh_11_err");
        xact(1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, "dm110_err");
        xact(1'b1, 32'h11, 32'h22222222, c_H, 32'h0, 1'b1, "sh_11_err");
        xact(1'b0, 32'h10, 32'h0, c_W, 32'h5AADBEEF, 1'b0, "lw_10_keep2");

        // Backpressure: response held while rsp_ready is low
        send(1'b0, 32'h10, 32'h0, c_W, "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'h5AADBEEF);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        take();
        check("bp_ready_after", 32'(req_ready), 32'd1);
        check("bp_valid_after", 32'(rsp_valid), 32'd0);

        // Address wrap modulo DEPTH_WORDS*4
        xact(1'b1, 32'h100, 32'h12345678, c_W, 32'h0, 1'b0, "sw_100");
        xact(1'b0, 32'h0, 32'h0, c_W, 32'h12345678, 1'b0, "lw_0_wrap");

        // Reset while BUSY abandons the store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h0;
        req_wdata  = 32'hFFFFFFFF;
        req_dmtype = c_W;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_valid2", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h0, 32'h0, c_W, 32'h12345678, 1'b0, "lw_0_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; legal range 1..4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; byte/halfword stores use low bits.
REQ-010 req_dmtype  input  3  access size: 000 word; 001 halfword; 010 halfword unsigned; 011 byte; 100 byte unsigned; 101-111 illegal.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  load result, extended per req_dmtype; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned or illegal access; qualified by rsp_valid.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-016 Acceptance: req_valid & req_ready at edge E0; all req_* fields are latched at E0 and ignored afterwards.
REQ-017 IDLE -> BUSY on acceptance; a down-counter enforces that rsp_valid rises at edge E0+LATENCY exactly.
REQ-018 BUSY -> RESP when the counter expires; the store commit and load read both occur at that same edge.
REQ-019 RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
REQ-020 RESP -> IDLE on the response handshake; req_ready rises the following cycle, giving no same-cycle back-to-back acceptance.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 Byte lane = addr[1:0]; halfword lane = addr[1].
REQ-023 Store word writes all 4 bytes.
REQ-024 Store halfword (001 or 010) writes wdata[15:0] into the selected halfword only.
REQ-025 Store byte (011 or 100) writes wdata[7:0] into the selected byte only.
REQ-026 All unselected bytes of a store are preserved.
REQ-027 Load 001 sign-extends the selected halfword; load 010 zero-extends it.
REQ-028 Load 011 sign-extends the selected byte; load 100 zero-extends it.
REQ-029 Error cases:
- word access with addr[1:0] != 0
- halfword access with addr[0] = 1
- req_dmtype 101-111
REQ-030 On an error: rsp_err = 1, rsp_rdata = 0, memory unchanged; the response still follows normal latency and handshake.
REQ-031 A store response has rsp_rdata = 0 and rsp_err = 0.
REQ-032 A load issued after a store's response handshake observes the stored data (no stale read).

Reset
REQ-033 While rst = 1: state = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-034 After rst falls, req_ready = 1 in the first clk cycle.
REQ-035 Reset asserted in BUSY before the commit edge abandons the request; no memory write occurs.
REQ-036 Memory array contents are not initialised by reset and are undefined until written.

Verification
REQ-037 LATENCY=2: accept sw addr 0x10 data 0xDEADBEEF at E0 -> rsp_valid at E2, rsp_err 0; then lw 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-038 Over word 0xDEADBEEF at 0x10: sb 0x5A at 0x13, then lw 0x10 -> 0x5AADBEEF; lb 0x13 -> 0x0000005A; lh 0x12 -> 0x00005AAD.
REQ-039 Word 0x80FF8001 at 0x20: lb 0x20 -> 0x00000001; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x22 -> 0x000080FF.
REQ-040 Error checks:
- sw at 0x12 -> rsp_err 1, rsp_rdata 0, word 0x10 unchanged
- lh at 0x11 -> rsp_err 1
- dmtype 110 -> rsp_err 1
REQ-041 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0; handshake -> req_ready 1 next cycle.
REQ-042 Wrap and reset checks:
- DEPTH_WORDS=64, sw 0x100 data 0x12345678 -> lw 0x0 returns 0x12345678
- assert rst one cycle after accepting sw 0x0 data 0xFFFFFFFF -> word 0x0 retains its prior value
